// File: rtl/rll_serializer.sv
// rll_serializer: packs 4/6/8-bit RLL codewords into a circular bit buffer and shifts them out one bit per clock.
// Optional macro RLL_SERIALIZER_NRZI_EN: registered NRZI line output with a one-cycle-delayed valid.
module rll_serializer #(
   parameter int DEPTH = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [3:0]                   encode4_i,
   input  logic [5:0]                   encode6_i,
   input  logic [7:0]                   encode8_i,
   input  logic [1:0]                   valid_i,
   output logic                         ch_bit_o,
   output logic                         ch_valid_o,
   output logic [$clog2(DEPTH+1)-1:0]   level_o,
   output logic                         overflow_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [DEPTH-1:0] buf_q, buf_d;
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [LW-1:0]    level_q, level_d;
   logic             ovf_q, ovf_d;

   logic [7:0] cw_left;
   int         len;
   int         off;
   int         nxt_tail;
   int         nxt_head;
   logic       pop;
   logic       push;
   logic       head_bit;

   assign pop      = (level_q != '0);
   assign head_bit = buf_q[head_q];

   always_comb begin
      cw_left = 8'h00;
      len     = 0;
      case (valid_i)
         2'b01:   begin cw_left = {encode4_i, 4'h0}; len = 4; end
         2'b10:   begin cw_left = {encode6_i, 2'b00}; len = 6; end
         2'b11:   begin cw_left = encode8_i;          len = 8; end
         default: ;
      endcase
   end

   // A codeword is taken whole or not at all; the pop this cycle frees one slot first.
   assign push = (len != 0) && ((int'(level_q) - (pop ? 1 : 0) + len) <= DEPTH);

   always_comb begin
      buf_d = buf_q;
      off   = 0;
      for (int i = 0; i < DEPTH; i++) begin
         off = i - int'(tail_q);
         if (off < 0) off = off + DEPTH;
         if (push && (off < len)) buf_d[i] = cw_left[3'(7 - off)];
      end
   end

   always_comb begin
      nxt_tail = int'(tail_q) + len;
      if (nxt_tail >= DEPTH) nxt_tail = nxt_tail - DEPTH;
      nxt_head = int'(head_q) + 1;
      if (nxt_head >= DEPTH) nxt_head = 0;
      tail_d  = push ? PW'(nxt_tail) : tail_q;
      head_d  = pop ? PW'(nxt_head) : head_q;
      level_d = LW'(int'(level_q) - (pop ? 1 : 0) + (push ? len : 0));
      ovf_d   = ovf_q | ((len != 0) && !push);
   end

   // Storage needs no reset: level_q alone decides which bits are live.
   always_ff @(posedge clk_i) begin
      buf_q <= buf_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         level_q <= level_d;
         ovf_q   <= ovf_d;
      end
   end

   assign level_o    = level_q;
   assign overflow_o = ovf_q;

`ifdef RLL_SERIALIZER_NRZI_EN
   logic line_q, vld_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         line_q <= 1'b0;
         vld_q  <= 1'b0;
      end else begin
         vld_q <= pop;
         if (pop && head_bit) line_q <= ~line_q;
      end
   end

   assign ch_bit_o   = line_q;
   assign ch_valid_o = vld_q;
`else
   assign ch_bit_o   = pop & head_bit;
   assign ch_valid_o = pop;
`endif

endmodule

// File: doc/rll_serializer.md
RLL_SERIALIZER -- requirements
Module: rll_serializer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32, meaning bit-buffer capacity in channel bits (legal range 8..64).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port encode4_i, input, 4 bits: 4-bit codeword from the RLL encoder.
REQ-005 The block SHALL have port encode6_i, input, 6 bits: 6-bit codeword.
REQ-006 The block SHALL have port encode8_i, input, 8 bits: 8-bit codeword.
REQ-007 The block SHALL have port valid_i, input, 2 bits: codeword select (00 none, 01 encode4_i, 10 encode6_i, 11 encode8_i).
REQ-008 The block SHALL have port ch_bit_o, output, 1 bit: serial channel bit.
REQ-009 The block SHALL have port ch_valid_o, output, 1 bit: ch_bit_o carries a buffered bit this cycle.
REQ-010 The block SHALL have port level_o, output, $clog2(DEPTH+1) bits: number of bits currently buffered.
REQ-011 The block SHALL have port overflow_o, output, 1 bit: sticky flag set when a codeword was dropped.

Function
REQ-012 The block SHALL sample valid_i and the selected codeword on every rising clk_i edge; there is no ready/backpressure toward the encoder.
REQ-013 The block SHALL append an accepted codeword to the buffer tail MSB-first, with length L = 4, 6 or 8 per valid_i.
REQ-014 The block SHALL drive ch_valid_o = (level_o != 0) combinationally from registered state.
REQ-015 When ch_valid_o=1, the block SHALL present the buffer head bit on ch_bit_o and remove it at the next rising edge (pop, one bit per cycle).
REQ-016 When ch_valid_o=0, ch_bit_o SHALL be 0.
REQ-017 Latency SHALL be one cycle: the MSB of a codeword accepted at edge N into an empty buffer appears on ch_bit_o during the cycle after edge N.
REQ-018 On simultaneous push and pop, the next level SHALL be level - 1 + L, with bit order preserved and no bit lost or duplicated.
REQ-019 A push SHALL be accepted only if level - pop + L <= DEPTH, where pop = 1 if ch_valid_o is high.
REQ-020 If the push condition fails, the whole codeword SHALL be dropped (no partial write), the pop SHALL proceed, and overflow_o SHALL be set.
REQ-021 overflow_o SHALL remain 1 until reset.
REQ-022 Filling exactly to DEPTH SHALL be legal and SHALL NOT set overflow_o.
REQ-023 Buffer storage SHALL be a circular bit array with head/tail pointers wrapping modulo DEPTH, and the wrap SHALL be transparent at the output.
REQ-024 valid_i = 00 SHALL never change buffer contents other than by pop.

Reset
REQ-025 While rst_ni=0, the block SHALL hold level_o=0, head and tail pointers at 0, overflow_o=0, ch_valid_o=0 and ch_bit_o=0, with no dependency on clk_i.
REQ-026 Reset asserted mid-stream SHALL discard all buffered bits immediately.
REQ-027 After rst_ni deasserts, the first rising edge SHALL accept a codeword normally.

Configuration
REQ-028 The block SHALL support the macro RLL_SERIALIZER_NRZI_EN.
REQ-029 With RLL_SERIALIZER_NRZI_EN defined, ch_bit_o SHALL be a registered NRZI line level that toggles at each pop whose head bit is 1 and holds otherwise, resets to 0, and holds when ch_valid_o=0.
REQ-030 With RLL_SERIALIZER_NRZI_EN defined, ch_valid_o SHALL be delayed one cycle to stay aligned with ch_bit_o, giving two-cycle latency.
REQ-031 Without RLL_SERIALIZER_NRZI_EN, ch_bit_o SHALL be the raw NRZ head bit as in REQ-015/016.

Verification
REQ-032 Empty buffer, valid_i=01, encode4_i=1000 for one cycle -> ch_bit_o 1,0,0,0 on the next 4 cycles, ch_valid_o high exactly 4 cycles, level_o peaks at 4.
REQ-033 Back-to-back valid_i=10 with encode6_i=001000, then valid_i=11 with encode8_i=00100100 -> 14 contiguous bits 00100000100100 with no gap, and level_o = 6, then 13.
REQ-034 DEPTH=32, valid_i=11 every cycle -> level_o grows by 7 per cycle; overflow_o rises on the first push that would exceed 32, and no partial codeword appears in the output stream.
REQ-035 Exactly-full case: push codewords totalling level 32 after pops -> overflow_o stays 0; the bit stream across the pointer wrap matches the input order.
REQ-036 rst_ni pulsed low mid-stream with level_o=10 -> outputs zero asynchronously; the next accepted encode4_i=0100 emits 0,1,0,0.
REQ-037 With RLL_SERIALIZER_NRZI_EN defined, codeword 1000 followed by 0100 from a reset level of 0 -> line levels 1,1,1,1,1,0,0,0.
